// File: rtl/cpu_trace_fifo_if.sv
// Drain port of the CPU retirement trace FIFO.
// The FIFO side uses the master modport, the consumer uses the slave modport.
// Optional macro: TRACE_TIMESTAMP_EN adds the 16-bit out_ts field to the port.
interface cpu_trace_fifo_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_op;
  logic [31:0] out_alu;
  logic [7:0]  out_cycles;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] out_ts;

  modport master (
    output out_valid, out_pc, out_op, out_alu, out_cycles, out_ts,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_op, out_alu, out_cycles, out_ts,
    output out_ready
  );
`else
  modport master (
    output out_valid, out_pc, out_op, out_alu, out_cycles,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_op, out_alu, out_cycles,
    output out_ready
  );
`endif
endinterface

// File: rtl/cpu_trace_fifo.sv
// Passive retirement tracer for the multicycle CPU.
// Watches the CPU state code and records one entry per retired instruction
// (PC+4 and opcode latched at decode, last ALU result, cycle count) into a
// DEPTH-entry FIFO drained over a valid/ready port. Retirements arriving while
// the FIFO is full are dropped and counted; the CPU is never stalled.
// Optional macro: TRACE_TIMESTAMP_EN stores a free-running 16-bit cycle
// timestamp with every entry and exposes it as out_ts.
module cpu_trace_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter logic [4:0]  FETCH_STATE = 5'd0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  trace_en,
  input  logic [4:0]            state_in,
  input  logic [31:0]           pc_in,
  input  logic [5:0]            op_in,
  input  logic [31:0]           alu_in,
  cpu_trace_fifo_if.master      out_if,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic [15:0]           drop_cnt
);

  // One trace record as held in storage.
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] alu;
    logic [7:0]  cyc;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts;
`endif
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [4:0]  prev_state_q, prev_state_d;
  logic [31:0] prev_alu_q,   prev_alu_d;
  logic        armed_q,      armed_d;
  logic [31:0] pc_lat_q,     pc_lat_d;
  logic [5:0]  op_lat_q,     op_lat_d;
  logic [7:0]  cyc_q,        cyc_d;
  logic [AW:0] wr_ptr_q,     wr_ptr_d;
  logic [AW:0] rd_ptr_q,     rd_ptr_d;
  logic        overflow_q,   overflow_d;
  logic [15:0] drop_cnt_q,   drop_cnt_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_q,         ts_d;
`endif

  entry_t      mem_q [DEPTH];
  entry_t      entry_d;
  entry_t      head;

  // Event strobes
  logic in_fetch;
  logic fetch_entry;
  logic retire;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;

  // ---------------------------------------------------------------------------
  // Retirement detection and FIFO handshake decode
  // ---------------------------------------------------------------------------
  // A retirement is the transition into fetch once the tracer has seen the CPU
  // leave the fetch it was reset into. fetch_entry alone (without trace_en)
  // still restarts the cycle counter so counts stay aligned to instructions.
  always_comb begin
    in_fetch    = (state_in == FETCH_STATE);
    fetch_entry = armed_q && in_fetch && (prev_state_q != FETCH_STATE);
    retire      = fetch_entry && trace_en;
    fifo_empty  = (wr_ptr_q == rd_ptr_q);
    fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop         = !fifo_empty && out_if.out_ready;
    // A pop in the same cycle frees the slot being written, so a full FIFO
    // still accepts the entry when the consumer is draining.
    push        = retire && (!fifo_full || pop);
    drop        = retire && fifo_full && !pop;
  end

  // ---------------------------------------------------------------------------
  // Instruction context tracking: previous-cycle samples, decode latch, cycles
  // ---------------------------------------------------------------------------
  always_comb begin
    prev_state_d = state_in;
    prev_alu_d   = alu_in;
    armed_d      = armed_q || !in_fetch;
    pc_lat_d     = pc_lat_q;
    op_lat_d     = op_lat_q;
    // First non-fetch cycle after fetch: PC has already advanced, so this is
    // PC+4 of the instruction being traced; it is recorded unchanged.
    if (!in_fetch && (prev_state_q == FETCH_STATE)) begin
      pc_lat_d = pc_in;
      op_lat_d = op_in;
    end
    // The fetch cycle that retires the previous instruction is cycle 1 of the
    // next one; otherwise count up and stick at 255.
    if (fetch_entry) begin
      cyc_d = 8'd1;
    end else if (cyc_q == 8'hFF) begin
      cyc_d = cyc_q;
    end else begin
      cyc_d = cyc_q + 8'd1;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  // Free-running timestamp; wraps naturally at 16 bits.
  always_comb begin
    ts_d = ts_q + 16'd1;
  end
`endif

  // Assemble the record written on a push edge.
  always_comb begin
    entry_d     = '0;
    entry_d.pc  = pc_lat_q;
    entry_d.op  = op_lat_q;
    entry_d.alu = prev_alu_q;
    entry_d.cyc = cyc_q;
`ifdef TRACE_TIMESTAMP_EN
    entry_d.ts  = ts_q;
`endif
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and loss accounting
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Context and control state; reset returns to "waiting to leave fetch".
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_state_q <= FETCH_STATE;
      prev_alu_q   <= '0;
      armed_q      <= 1'b0;
      pc_lat_q     <= '0;
      op_lat_q     <= '0;
      cyc_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      prev_state_q <= prev_state_d;
      prev_alu_q   <= prev_alu_d;
      armed_q      <= armed_d;
      pc_lat_q     <= pc_lat_d;
      op_lat_q     <= op_lat_d;
      cyc_q        <= cyc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  // Timestamp counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end
`endif

  // Entry storage; cleared on reset so the drain port reads zero until the
  // first entry lands.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= entry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head of FIFO read combinationally from storage
  // ---------------------------------------------------------------------------
  always_comb begin
    head = mem_q[rd_ptr_q[AW-1:0]];
  end

  assign out_if.out_valid  = !fifo_empty;
  assign out_if.out_pc     = head.pc;
  assign out_if.out_op     = head.op;
  assign out_if.out_alu    = head.alu;
  assign out_if.out_cycles = head.cyc;
`ifdef TRACE_TIMESTAMP_EN
  assign out_if.out_ts     = head.ts;
`endif
  assign count             = wr_ptr_q - rd_ptr_q;
  assign overflow          = overflow_q;
  assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Testbench for cpu_trace_fifo: instruction-level reference model feeds a
// scoreboard queue; an independent monitor compares every popped entry.
// Honors TRACE_TIMESTAMP_EN when defined for the DUT build.
module tb_cpu_trace_fifo;
  localparam int DEPTH = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        trace_en = 1'b0;
  logic [4:0]  state_in = '0;
  logic [31:0] pc_in = '0;
  logic [5:0]  op_in = '0;
  logic [31:0] alu_in = '0;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  cpu_trace_fifo_if tif();

  cpu_trace_fifo #(.DEPTH(16), .AW(4), .FETCH_STATE(5'd0)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .trace_en (trace_en),
    .state_in (state_in),
    .pc_in    (pc_in),
    .op_in    (op_in),
    .alu_in   (alu_in),
    .out_if   (tif),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] alu;
    logic [7:0]  cyc;
    logic [15:0] ts;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: instruction-level view of the CPU trace
  int          cyc_no;        // cycles since reset release
  int          last_restart;  // cycle on which the current instruction began
  logic [4:0]  m_prev;
  logic        m_armed;
  logic [31:0] m_pc;
  logic [5:0]  m_op;
  logic [31:0] m_alu;
  int          m_count;
  logic        m_ovf;
  int          m_drop;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rv(int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom % 2);
  endfunction

  task automatic do_reset(int n, logic [4:0] st);
    Reset = 1'b1;
    tif.out_ready = 1'b0;
    state_in = st;
    repeat (n) @(posedge Clk);
    #1;
    Reset = 1'b0;
    state_in = 5'd0;
    sb.delete();
    cyc_no = 0; last_restart = 0;
    m_prev = 5'd0; m_armed = 1'b0;
    m_pc = '0; m_op = '0; m_alu = '0;
    m_count = 0; m_ovf = 1'b0; m_drop = 0;
  endtask

  // Drive one CPU cycle, predict its effect, advance the clock, check status.
  task automatic step(logic [4:0] st, logic [31:0] pc, logic [5:0] op,
                      logic [31:0] alu, logic en, logic rdy);
    logic fe;
    logic pop;
    int   el;
    exp_t e;
    state_in = st; pc_in = pc; op_in = op; alu_in = alu;
    trace_en = en; tif.out_ready = rdy;
    fe  = m_armed && (st == 5'd0) && (m_prev != 5'd0);
    pop = (m_count > 0) && rdy;
    if (fe && en) begin
      if (m_count < DEPTH || pop) begin
        el    = cyc_no - last_restart;
        e.pc  = m_pc;
        e.op  = m_op;
        e.alu = m_alu;
        e.cyc = (el > 255) ? 8'd255 : 8'(el);
        e.ts  = 16'(cyc_no);
        sb.push_back(e);
        m_count++;
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (pop) m_count--;
    if (fe) last_restart = cyc_no;
    if (st != 5'd0 && m_prev == 5'd0) begin
      m_pc = pc;
      m_op = op;
    end
    if (st != 5'd0) m_armed = 1'b1;
    m_prev = st;
    m_alu  = alu;
    cyc_no++;
    @(posedge Clk);
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("out_valid", 32'(tif.out_valid), 32'(m_count > 0));
  endtask

  // Fetch cycle followed by `body` non-fetch cycles of one instruction.
  task automatic instr(int body, logic en, int rmode, logic [31:0] pc);
    logic [5:0] op;
    op = 6'($urandom);
    step(5'd0, $urandom, 6'($urandom), $urandom, en, rv(rmode));
    for (int b = 0; b < body; b++) begin
      step(5'(1 + (b % 4)), pc, op, $urandom, en, rv(rmode));
    end
  endtask

  task automatic drain(int n);
    for (int k = 0; k < n; k++) step(5'd0, '0, '0, '0, 1'b1, 1'b1);
  endtask

  // Monitor: compares each accepted head entry against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset === 1'b0 && tif.out_valid === 1'b1 && tif.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 32'(tif.out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          $display("[TB] pop pc=%h op=%h alu=%h cycles=%0d", tif.out_pc,
                   tif.out_op, tif.out_alu, tif.out_cycles);
          chk("pop_pc", tif.out_pc, e.pc);
          chk("pop_op", 32'(tif.out_op), 32'(e.op));
          chk("pop_alu", tif.out_alu, e.alu);
          chk("pop_cycles", 32'(tif.out_cycles), 32'(e.cyc));
`ifdef TRACE_TIMESTAMP_EN
          chk("pop_ts", 32'(tif.out_ts), 32'(e.ts));
`endif
        end
      end
    end
  end

  initial begin
    tif.out_ready = 1'b0;

    // 1. Reset state
    do_reset(3, 5'd0);
    chk("rst_valid", 32'(tif.out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_pc", tif.out_pc, 32'd0);

    // 2. Single instruction 0,1,2,3,0
    step(5'd0, 32'd0, 6'h00, 32'h0,  1'b1, 1'b0);
    step(5'd1, 32'd4, 6'h08, 32'h0,  1'b1, 1'b0);
    step(5'd2, 32'd4, 6'h08, 32'h0,  1'b1, 1'b0);
    step(5'd3, 32'd4, 6'h08, 32'h10, 1'b1, 1'b0);
    step(5'd0, 32'd8, 6'h00, 32'h0,  1'b1, 1'b0);
    chk("t2_valid", 32'(tif.out_valid), 32'd1);
    chk("t2_pc", tif.out_pc, 32'd4);
    chk("t2_op", 32'(tif.out_op), 32'h08);
    chk("t2_alu", tif.out_alu, 32'h10);
    chk("t2_cycles", 32'(tif.out_cycles), 32'd4);
    drain(2);

    // 3. Overfill by two, then drain in order
    for (int i = 0; i < 18; i++) instr(1, 1'b1, 0, 32'h100 + 32'(4 * i));
    step(5'd0, '0, '0, '0, 1'b1, 1'b0);
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    drain(17);
    chk("t3_empty", 32'(tif.out_valid), 32'd0);

    // 4. Full FIFO with simultaneous pop and retire
    for (int i = 0; i < 17; i++) instr(1, 1'b1, 0, 32'h200 + 32'(4 * i));
    step(5'd0, '0, '0, '0, 1'b1, 1'b1);
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    drain(17);

    // 5. Reset mid-instruction with 5 entries queued
    for (int i = 0; i < 6; i++) instr(1, 1'b1, 0, 32'h300 + 32'(4 * i));
    step(5'd2, 32'h318, 6'h3, 32'h0, 1'b1, 1'b0);
    chk("t5_pre_count", 32'(count), 32'd5);
    do_reset(1, 5'd2);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_valid", 32'(tif.out_valid), 32'd0);
    step(5'd0, 32'h0,   6'h0,  32'h0,  1'b1, 1'b0);
    step(5'd1, 32'h404, 6'h21, 32'h55, 1'b1, 1'b0);
    step(5'd0, 32'h0,   6'h0,  32'h0,  1'b1, 1'b0);
    chk("t5_one", 32'(count), 32'd1);
    drain(2);

    // 6. Tracing disabled, then a very long instruction
    for (int i = 0; i < 4; i++) instr(2, 1'b0, 0, 32'h500 + 32'(4 * i));
    step(5'd0, '0, '0, '0, 1'b0, 1'b0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    for (int k = 0; k < 300; k++) step(5'd1, 32'h600, 6'h2a, $urandom, 1'b1, 1'b0);
    step(5'd0, '0, '0, '0, 1'b1, 1'b0);
    chk("t6_cycles", 32'(tif.out_cycles), 32'd255);
    chk("t6_pc", tif.out_pc, 32'h600);
    drain(2);

    // Back-to-back 4-cycle instructions (timestamp spacing), then random mix
    for (int i = 0; i < 4; i++) instr(3, 1'b1, 1, 32'h700 + 32'(4 * i));
    for (int i = 0; i < 80; i++) begin
      instr(int'($urandom_range(1, 6)), 1'(($urandom % 4) != 0), 2, $urandom);
    end
    step(5'd0, '0, '0, '0, 1'b1, 1'b0);
    drain(20);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
